// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM driver: default word width and the word type.
package pwm_pkg;

  localparam int PWM_SIZE_DFLT = 16;

  typedef logic [PWM_SIZE_DFLT-1:0] pwm_word_t;

endpackage : pwm_pkg

// File: rtl/pwm_period_counter.sv
// Period counter: runs 0..per_sh-1 and strobes a shadow load on the terminal cycle
// or on every cycle while the shadowed period is zero (driver disabled).
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int PWM_SIZE = PWM_SIZE_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_SIZE-1:0] per_sh,
  output logic [PWM_SIZE-1:0] cnt,
  output logic                load
);

  logic [PWM_SIZE-1:0] cnt_q;
  logic [PWM_SIZE-1:0] cnt_d;
  logic                disabled;
  logic                terminal;

  always_comb begin
    disabled = (per_sh == '0);
    terminal = 1'b0;
    // per_sh-1 is only evaluated when per_sh is non-zero, so it cannot underflow.
    if (!disabled) begin
      terminal = (cnt_q == per_sh - 1'b1);
    end
    load  = disabled || terminal;
    cnt_d = cnt_q + 1'b1;
    if (load) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : pwm_period_counter

// File: rtl/pwm_driver.sv
// Single-channel PWM generator with period/duty shadowed until a period boundary,
// so the output never carries a truncated or runt pulse.
module pwm_driver
  import pwm_pkg::*;
#(
  parameter int PWM_SIZE = PWM_SIZE_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_SIZE-1:0] pwm_period,
  input  logic [PWM_SIZE-1:0] pwm_duty,
  output logic                pwm_out
);

  logic [PWM_SIZE-1:0] per_sh_q;
  logic [PWM_SIZE-1:0] per_sh_d;
  logic [PWM_SIZE-1:0] duty_sh_q;
  logic [PWM_SIZE-1:0] duty_sh_d;
  logic                pwm_out_q;
  logic                pwm_out_d;
  logic [PWM_SIZE-1:0] cnt;
  logic                load;

  pwm_period_counter #(
    .PWM_SIZE(PWM_SIZE)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .per_sh(per_sh_q),
    .cnt   (cnt),
    .load  (load)
  );

  always_comb begin
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    if (load) begin
      per_sh_d  = pwm_period;
      duty_sh_d = pwm_duty;
    end
    // Compare uses the shadowed settings only; inputs never reach the output directly.
    pwm_out_d = (per_sh_q != '0) && (cnt < duty_sh_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule : pwm_driver

// File: tb/tb_pwm_driver.sv
// Directed bench for pwm_driver: checks the output waveform cycle by cycle against hand-derived patterns.
module tb_pwm_driver;

  logic        clk;
  logic        rst;
  logic [15:0] pwm_period;
  logic [15:0] pwm_duty;
  logic        pwm_out;

  int checks_cnt = 0;
  int errors_cnt = 0;

  pwm_driver #(.PWM_SIZE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_period(pwm_period),
    .pwm_duty  (pwm_duty),
    .pwm_out   (pwm_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // For each of nper periods: nhigh cycles high, then nlow cycles low.
  task automatic check_wave(input string tag, input int nhigh, input int nlow, input int nper);
    int bad_before;
    bad_before = errors_cnt;
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < nhigh; i++) begin
        step();
        check($sformatf("%s_p%0d_hi%0d", tag, p, i), pwm_out, 1'b1);
      end
      for (int i = 0; i < nlow; i++) begin
        step();
        check($sformatf("%s_p%0d_lo%0d", tag, p, i), pwm_out, 1'b0);
      end
    end
    $display("wave %-10s hi=%0d lo=%0d periods=%0d new_errors=%0d",
             tag, nhigh, nlow, nper, errors_cnt - bad_before);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    pwm_period = '0;
    pwm_duty   = '0;

    // 1. Reset and disabled output
    step();
    step();
    check("reset_out", pwm_out, 1'b0);
    rst = 1'b0;
    check_wave("disabled", 0, 4, 1);

    // 2. 50% duty, first rise two edges after the inputs change
    pwm_period = 16'd16;
    pwm_duty   = 16'd8;
    step();
    check("rise_early", pwm_out, 1'b0);
    check_wave("d50", 8, 8, 2);

    // 3. Duty change mid-high-phase only applies from the next period
    check_wave("d50_part", 3, 0, 1);
    pwm_duty = 16'd4;
    check_wave("d50_rest", 5, 8, 1);
    check_wave("d25", 4, 12, 2);

    // 4. 75%, 100%, over-range and 0%
    pwm_duty = 16'd12;
    check_wave("d25_hold", 4, 12, 1);
    check_wave("d75", 12, 4, 2);
    pwm_duty = 16'd16;
    check_wave("d75_hold", 12, 4, 1);
    check_wave("d100", 16, 0, 2);
    pwm_duty = 16'd20;
    check_wave("d120", 16, 0, 3);
    pwm_duty = 16'd0;
    check_wave("d0_hold", 16, 0, 1);
    check_wave("d0", 0, 16, 2);

    // 5. One-cycle period, then disable at the next terminal
    pwm_period = 16'd1;
    pwm_duty   = 16'd1;
    check_wave("p1_hold", 0, 16, 1);
    check_wave("p1", 1, 0, 8);
    pwm_period = 16'd0;
    check_wave("p0_last", 1, 0, 1);
    check_wave("p0", 0, 1, 5);

    // 6. Reset mid-high-phase, clean restart from cnt=0
    pwm_period = 16'd10;
    pwm_duty   = 16'd6;
    step();
    check("p10_load", pwm_out, 1'b0);
    check_wave("p10_pre", 3, 0, 1);
    rst = 1'b1;
    step();
    check("rst_mid", pwm_out, 1'b0);
    rst = 1'b0;
    check_wave("p10_load2", 0, 1, 1);
    check_wave("p10", 6, 4, 2);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_pwm_driver
